// File: rtl/tank_pkg.sv
// Shared types and default geometry for the tank gauge panel and hold-repeat input.
package tank_pkg;

    // Hold-to-repeat phases: first press, wait, slow repeat, fast repeat.
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        FAST
    } hold_state_t;

    localparam int SEL_W = 3;

    localparam int DEF_X0    = 191;
    localparam int DEF_Y0    = 8;
    localparam int DEF_ROW_H = 8;

endpackage

// File: rtl/tank_hold_repeat.sv
// Hold-to-repeat/accelerate FSM: turns a held inc/dec pair into a signed step per frame.
module tank_hold_repeat
    import tank_pkg::*;
#(
    parameter int REPEAT_DELAY = 16,
    parameter int FAST_AFTER   = 32,
    parameter int FAST_STEP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              inc,
    input  logic              dec,
    input  logic              force_idle,
    output logic signed [7:0] step
);

    localparam int CNT_W = 16;

    hold_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [7:0]       mag;
    logic             press;

    // Next phase and step size; releasing, reversing or a forced idle cancels the hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mag     = '0;
        press   = inc ^ dec;
        if (force_idle || !press || (state_q != IDLE && dec != neg_q)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mag     = 8'd1;
                    neg_d   = dec;
                    cnt_d   = '0;
                    state_d = DELAY;
                end
                DELAY: begin
                    if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    mag = 8'd1;
                    if (cnt_q == CNT_W'(FAST_AFTER - 1)) begin
                        cnt_d   = '0;
                        state_d = FAST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FAST: begin
                    mag = 8'(FAST_STEP);
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        step = neg_d ? -$signed(mag) : $signed(mag);
    end

    // Hold state advances only on frame ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else if (tick) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/tank_gauge_ctrl.sv
// Gauge panel: saturating per-gauge values, selection, lock, and registered panel pixels.
module tank_gauge_ctrl
    import tank_pkg::*;
#(
    parameter int NUM_GAUGES   = 2,
    parameter int VAL_W        = 8,
    parameter int RESET_VAL    = 0,
    parameter int X0           = DEF_X0,
    parameter int Y0           = DEF_Y0,
    parameter int ROW_H        = DEF_ROW_H,
    parameter int REPEAT_DELAY = 16,
    parameter int FAST_AFTER   = 32,
    parameter int FAST_STEP    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        inc,
    input  logic                        dec,
    input  logic                        sel_next,
    input  logic                        sel_prev,
    input  logic                        lock,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    output logic [NUM_GAUGES*VAL_W-1:0] values,
    output logic [SEL_W-1:0]            sel,
    output logic                        pix_border,
    output logic                        pix_fill,
    output logic                        pix_cursor
);

    localparam logic [VAL_W:0] MAXV = (VAL_W+1)'(2**VAL_W - 1);
    localparam logic [10:0] PX0  = 11'(X0);
    localparam logic [10:0] PXR  = 11'(X0 + 2**VAL_W);
    localparam logic [10:0] PY0  = 11'(Y0);
    localparam logic [10:0] PRH  = 11'(NUM_GAUGES * ROW_H);
    localparam logic [10:0] PCL  = 11'(X0 - 6);
    localparam logic [10:0] PCR  = 11'(X0 - 3);
    localparam logic [10:0] PROW = 11'(ROW_H);

    logic [NUM_GAUGES-1:0][VAL_W-1:0] val_q;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              pn_q, pp_q;
    logic              ne, pe, sel_chg;
    logic signed [7:0] step;
    logic [7:0]        step_abs;
    logic [VAL_W:0]    cur, mag, sum;
    logic [VAL_W-1:0]  nxt;

    assign ne      = sel_next & ~pn_q;
    assign pe      = sel_prev & ~pp_q;
    assign sel_chg = (ne ^ pe) & ~lock;
    assign values  = val_q;
    assign sel     = sel_q;

    tank_hold_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .FAST_AFTER  (FAST_AFTER),
        .FAST_STEP   (FAST_STEP)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .tick      (frame_tick),
        .inc       (inc),
        .dec       (dec),
        .force_idle(lock | sel_chg),
        .step      (step)
    );

    // Wrapped selection and saturated next value for the selected gauge.
    always_comb begin
        sel_d = sel_q;
        if (ne) sel_d = (sel_q == SEL_W'(NUM_GAUGES - 1)) ? '0 : sel_q + 1'b1;
        else if (pe) sel_d = (sel_q == '0) ? SEL_W'(NUM_GAUGES - 1) : sel_q - 1'b1;
        cur = '0;
        for (int i = 0; i < NUM_GAUGES; i++)
            if (sel_q == SEL_W'(i)) cur = {1'b0, val_q[i]};
        step_abs = step[7] ? 8'(-step) : 8'(step);
        mag      = (VAL_W+1)'(step_abs);
        sum      = cur + mag;
        nxt      = cur[VAL_W-1:0];
        if (!step[7]) nxt = (sum > MAXV) ? MAXV[VAL_W-1:0] : sum[VAL_W-1:0];
        else if (cur < mag) nxt = '0;
        else nxt = VAL_W'(cur - mag);
    end

    // Frame-rate state: edge history always, selection/values only when unlocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_GAUGES; i++) val_q[i] <= VAL_W'(RESET_VAL);
            sel_q <= '0;
            pn_q  <= 1'b0;
            pp_q  <= 1'b0;
        end else if (frame_tick) begin
            pn_q <= sel_next;
            pp_q <= sel_prev;
            if (sel_chg) begin
                sel_q <= sel_d;
            end else if (!lock) begin
                for (int i = 0; i < NUM_GAUGES; i++)
                    if (sel_q == SEL_W'(i)) val_q[i] <= nxt;
            end
        end
    end

    logic [10:0] xx, yy, r, lo, hi;
    logic        b_d, f_d, c_d, in_row;

    // Panel geometry decode; 11-bit unsigned keeps y<Y0 out of every row.
    always_comb begin
        xx = {1'b0, x};
        yy = {1'b0, y};
        r  = yy - PY0;
        b_d = ((xx == PX0 || xx == PXR) && yy >= PY0 && r <= PRH) ||
              (r <= PRH && (r % PROW) == 11'd0 && xx >= PX0 && xx <= PXR);
        f_d = 1'b0;
        c_d = 1'b0;
        lo  = '0;
        hi  = '0;
        in_row = 1'b0;
        for (int i = 0; i < NUM_GAUGES; i++) begin
            lo     = 11'(Y0 + i * ROW_H);
            hi     = 11'(Y0 + (i + 1) * ROW_H);
            in_row = (yy > lo) && (yy < hi);
            if (in_row && xx >= PX0 && xx <= PX0 + 11'(val_q[i])) f_d = 1'b1;
            if (in_row && sel_q == SEL_W'(i) && xx >= PCL && xx <= PCR) c_d = 1'b1;
        end
    end

    // Pixel flags registered every cycle for the colour mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_border <= 1'b0;
            pix_fill   <= 1'b0;
            pix_cursor <= 1'b0;
        end else begin
            pix_border <= b_d;
            pix_fill   <= f_d;
            pix_cursor <= c_d;
        end
    end

endmodule
